// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: owns the architectural PC, redirects on branch/jump,
// squashes wrong-path fetches with a flush pulse plus bubble window, and holds on stall/halt.
module pc_fetch_unit #(
    parameter int unsigned              PC_WIDTH     = 16,
    parameter logic [PC_WIDTH-1:0]      RESET_VECTOR = '0,
    parameter int unsigned              BUBBLES      = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_in,
    input  logic                branch_sel,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                jump_en,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                halt_in,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic [PC_WIDTH-1:0] pc_plus1,
    output logic                fetch_valid,
    output logic                flush_out,
    output logic                halted
);

    typedef enum logic [1:0] {StRun, StFlush, StHalt} state_e;

    localparam logic [2:0] BubbleLoad = 3'(BUBBLES);

    state_e              state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [2:0]          cnt_q;
    logic                flush_q;

    assign pc_plus1    = pc_q + PC_WIDTH'(1);
    assign pc_out      = pc_q;
    assign flush_out   = flush_q;
    assign fetch_valid = (state_q == StRun);
    assign halted      = (state_q == StHalt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            pc_q    <= RESET_VECTOR;
            cnt_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            unique case (state_q)
                StRun: begin
                    if (branch_sel) begin
                        pc_q    <= branch_target;
                        flush_q <= 1'b1;
                        cnt_q   <= BubbleLoad;
                        state_q <= StFlush;
                    end else if (halt_in) begin
                        state_q <= StHalt;
                    end else if (jump_en) begin
                        pc_q    <= jump_target;
                        flush_q <= 1'b1;
                        cnt_q   <= BubbleLoad;
                        state_q <= StFlush;
                    end else if (!stall_in) begin
                        pc_q <= pc_plus1;
                    end
                end
                StFlush: begin
                    // Jump/halt here belong to squashed instructions; only a branch redirects.
                    if (branch_sel) begin
                        pc_q    <= branch_target;
                        flush_q <= 1'b1;
                        cnt_q   <= BubbleLoad;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                        if (!stall_in) begin
                            pc_q <= pc_plus1;
                        end
                        if (cnt_q == 3'd1) begin
                            state_q <= StRun;
                        end
                    end
                end
                StHalt: begin
                    state_q <= StHalt;
                end
                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit with hand-computed expected values.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_in;
    logic        branch_sel;
    logic [15:0] branch_target;
    logic        jump_en;
    logic [15:0] jump_target;
    logic        halt_in;
    logic [15:0] pc_out;
    logic [15:0] pc_plus1;
    logic        fetch_valid;
    logic        flush_out;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    pc_fetch_unit #(
        .PC_WIDTH     (16),
        .RESET_VECTOR (16'h0000),
        .BUBBLES      (2)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .stall_in      (stall_in),
        .branch_sel    (branch_sel),
        .branch_target (branch_target),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .halt_in       (halt_in),
        .pc_out        (pc_out),
        .pc_plus1      (pc_plus1),
        .fetch_valid   (fetch_valid),
        .flush_out     (flush_out),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall_in   = 1'b0;
        branch_sel = 1'b0;
        jump_en    = 1'b0;
        halt_in    = 1'b0;
    endtask

    task automatic expect_state(input string tag, input logic [15:0] pc, input logic fv,
                                input logic fl, input logic hl);
        check_eq({tag, ".pc"}, 32'(pc_out), 32'(pc));
        check_eq({tag, ".valid"}, 32'(fetch_valid), 32'(fv));
        check_eq({tag, ".flush"}, 32'(flush_out), 32'(fl));
        check_eq({tag, ".halted"}, 32'(halted), 32'(hl));
    endtask

    initial begin
        rst           = 1'b1;
        branch_target = 16'h0000;
        jump_target   = 16'h0000;
        idle_inputs();
        step();
        step();
        expect_state("reset", 16'h0000, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;

        // Free-running increment
        for (int i = 1; i <= 5; i++) begin
            step();
            expect_state($sformatf("inc%0d", i), 16'(i), 1'b1, 1'b0, 1'b0);
        end
        check_eq("plus1_at5", 32'(pc_plus1), 32'h0006);

        // Branch wins over simultaneous jump
        branch_sel = 1'b1; branch_target = 16'h0040;
        jump_en    = 1'b1; jump_target   = 16'h0099;
        step();
        idle_inputs();
        expect_state("br_0", 16'h0040, 1'b0, 1'b1, 1'b0);
        step();
        expect_state("br_1", 16'h0041, 1'b0, 1'b0, 1'b0);
        step();
        expect_state("br_2", 16'h0042, 1'b1, 1'b0, 1'b0);

        // Jump to 7 with stall held: bubbles still count down while PC holds
        jump_en = 1'b1; jump_target = 16'h0007; stall_in = 1'b1;
        step();
        jump_en = 1'b0;
        expect_state("jst_0", 16'h0007, 1'b0, 1'b1, 1'b0);
        step();
        expect_state("jst_1", 16'h0007, 1'b0, 1'b0, 1'b0);
        step();
        expect_state("jst_2", 16'h0007, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_state($sformatf("stall%0d", i), 16'h0007, 1'b1, 1'b0, 1'b0);
        end
        jump_en = 1'b1; jump_target = 16'h0010;
        step();
        idle_inputs();
        expect_state("jovs_0", 16'h0010, 1'b0, 1'b1, 1'b0);
        step();
        expect_state("jovs_1", 16'h0011, 1'b0, 1'b0, 1'b0);
        step();
        expect_state("jovs_2", 16'h0012, 1'b1, 1'b0, 1'b0);

        // Back-to-back branches; jump during FLUSH ignored
        branch_sel = 1'b1; branch_target = 16'h0020;
        step();
        expect_state("bb_0", 16'h0020, 1'b0, 1'b1, 1'b0);
        branch_target = 16'h0030;
        step();
        branch_sel = 1'b0;
        expect_state("bb_1", 16'h0030, 1'b0, 1'b1, 1'b0);
        jump_en = 1'b1; jump_target = 16'h0099; halt_in = 1'b1;
        step();
        idle_inputs();
        expect_state("bb_2", 16'h0031, 1'b0, 1'b0, 1'b0);
        step();
        expect_state("bb_3", 16'h0032, 1'b1, 1'b0, 1'b0);

        // Reach pc=9 then halt
        jump_en = 1'b1; jump_target = 16'h0007;
        step();
        idle_inputs();
        step();
        step();
        expect_state("pre_halt", 16'h0009, 1'b1, 1'b0, 1'b0);
        halt_in = 1'b1;
        step();
        expect_state("halt_0", 16'h0009, 1'b0, 1'b0, 1'b1);
        jump_en = 1'b1; jump_target = 16'h0077;
        branch_sel = 1'b1; branch_target = 16'h0055;
        for (int i = 1; i <= 5; i++) begin
            step();
            expect_state($sformatf("halt_%0d", i), 16'h0009, 1'b0, 1'b0, 1'b1);
        end
        idle_inputs();
        #2 rst = 1'b1;
        #1 expect_state("async_rst", 16'h0000, 1'b1, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        expect_state("rst_hold", 16'h0000, 1'b1, 1'b0, 1'b0);

        // Wrap-around
        branch_sel = 1'b1; branch_target = 16'hFFFE;
        step();
        idle_inputs();
        expect_state("wrap_0", 16'hFFFE, 1'b0, 1'b1, 1'b0);
        step();
        expect_state("wrap_1", 16'hFFFF, 1'b0, 1'b0, 1'b0);
        check_eq("wrap_plus1", 32'(pc_plus1), 32'h0000);
        step();
        expect_state("wrap_2", 16'h0000, 1'b1, 1'b0, 1'b0);
        step();
        expect_state("wrap_3", 16'h0001, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
